uart_config_sequencer: RTL
==========================

Name: uart_config_sequencer

Overview:
- Byte-command controller that programs the UART configuration register file from a stream of received bytes.
- Collects a header (address) plus little-endian value bytes and waits for the transmitter to go idle. Then issues a single-cycle store strobe on the register's address/value/store port and returns an ACK/NAK byte.
- Sits between the UART RX byte output, the config register write port and the TX byte input.

Parameters:
- COUNTER_WIDTH, 24, width of cfg_value. Must match the config register's value port. Legal range 8..32.
- TIMEOUT, 1000000, inter-byte timeout in clk cycles while a command is partially received. Must be ≥ 2.
- VALUE_BYTES (localparam), (COUNTER_WIDTH+7)/8, number of value bytes per command.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_busy  in  1  high while the UART transmitter is mid-frame
- cfg_address  out  3  config register address
- cfg_value  out  COUNTER_WIDTH  config register value
- cfg_store  out  1  one-cycle store strobe to the config register
- ack_data  out  8  response byte to the TX path
- ack_valid  out  1  response valid; held until ack_ready
- ack_ready  in  1  TX path accepts the response
- error  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset: state=IDLE; cfg_address=0, cfg_value=0, cfg_store=0, ack_data=0, ack_valid=0, error=0; timeout counter=0; byte counter=0.
- Reset mid-command discards any partial command. No store is issued.
- Header format: bits[7:5] must be 3'b101; bits[4:3] are ignored; bits[2:0] are the address.
- IDLE state, rx_valid:
  - Valid header → latch the address, clear the value shift register, go to COLLECT.
  - Bad header → drop the byte, pulse error, stay in IDLE.
- COLLECT state:
  - Each rx_valid byte is placed at value[8k +: 8], with k = 0..VALUE_BYTES-1 (LSB first).
  - Bits beyond COUNTER_WIDTH-1 are discarded.
  - The timeout counter resets on each byte. If it reaches TIMEOUT-1 with no byte, pulse error and go to IDLE; no store, no ack.
  - After the last value byte: go to CHECK (with CHECKSUM) or COMMIT (without).
- COMMIT state:
  - Addresses 6 and 7 are reserved: no store; set ack_data = 8'hE0 | address; go to ACK.
  - Otherwise wait while tx_busy=1. In the first cycle with tx_busy=0, drive cfg_store=1 for exactly one cycle, with cfg_address/cfg_value updated in that same cycle. Then set ack_data = 8'hA0 | address and go to ACK.
  - Minimum latency: cfg_store is high in the cycle after the clock edge that accepts the last byte.
- ACK state:
  - ack_valid=1 with ack_data stable until the cycle where ack_ready=1. Then deassert ack_valid and go to IDLE.
  - ack_ready=1 on the first ACK cycle completes the handshake in one cycle.
- rx_valid in COMMIT or ACK (overrun): drop the byte, pulse error, state unaffected.
- cfg_address and cfg_value hold their last committed values between stores.
- cfg_store is never asserted outside COMMIT.
- Simultaneous timeout expiry and rx_valid in COLLECT: the byte wins and the counter resets.

Optional Feature:
- Macro: UART_CFG_CHECKSUM_EN.
- Enabled: one extra byte follows the value bytes. It must equal the XOR of the header and all value bytes.
  - Match → COMMIT.
  - Mismatch → no store; ack_data = 8'hC0 | address; pulse error; go to ACK.
  - The timeout also applies while waiting for the checksum byte.
- Disabled: no CHECK state; a command is header plus VALUE_BYTES bytes.

Test Plan (COUNTER_WIDTH=16, VALUE_BYTES=2):
- Send 0xA1, 0x00, 0x0B with tx_busy=0 → one cfg_store pulse, cfg_address=1, cfg_value=16'h0B00. Then ack_data=0xA1 with ack_valid held until ack_ready.
- Send 0xA3, 0x07, 0x00 with tx_busy=1 for 20 cycles after the last byte → cfg_store is delayed until the first tx_busy=0 cycle; cfg_address=3, cfg_value=7.
- Send 0x42, then 0xA6, 0x01, 0x00 → error pulse on 0x42. The second command is NAKed with ack_data=0xE6, no cfg_store, and outputs hold their previous values.
- Send 0xA2, 0x05, then idle TIMEOUT cycles → error pulse, return to IDLE. Then 0xA2, 0x08, 0x00 → cfg_value=8.
- Assert rst after 0xA1, 0x34 → no store. Next 0xA1, 0x80, 0x25 → cfg_value=16'h2580.
- With UART_CFG_CHECKSUM_EN: send 0xA1, 0x00, 0x0B, 0xAA → ack 0xA1 and store. Then send 0xA1, 0x00, 0x0B, 0x00 → ack 0xC1, error pulse, no store.

Source files
------------

// File: rtl/uart_config_sequencer.sv
// uart_config_sequencer: turns a stream of UART RX bytes into single-cycle
// writes on the config register port, then answers each command with an
// ACK/NAK byte on the TX path.
//
// Command: header 101xxaaa (aaa = address), then VALUE_BYTES value bytes,
// least significant byte first. Addresses 6 and 7 are reserved and are NAKed.
//
// Optional build macro UART_CFG_CHECKSUM_EN: one extra byte follows the
// value bytes and must equal the XOR of the header and all value bytes.
//
// state   | meaning
// IDLE    | waiting for a header byte
// COLLECT | shifting in value bytes, inter-byte timeout running
// CHECK   | waiting for the checksum byte (checksum build only)
// COMMIT  | store pending until the transmitter is idle
// ACK     | response byte offered until ack_ready
module uart_config_sequencer #(
    parameter int COUNTER_WIDTH = 24,
    parameter int TIMEOUT       = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     tx_busy,
    output logic [2:0]               cfg_address,
    output logic [COUNTER_WIDTH-1:0] cfg_value,
    output logic                     cfg_store,
    output logic [7:0]               ack_data,
    output logic                     ack_valid,
    input  logic                     ack_ready,
    output logic                     error
);

    localparam int VALUE_BYTES = (COUNTER_WIDTH + 7) / 8;
    localparam int TW          = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    VB_LAST  = 3'(VALUE_BYTES - 1);

`ifdef UART_CFG_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_CHECK, S_COMMIT, S_ACK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_COMMIT, S_ACK} state_t;
`endif

    state_t                   state_q;
    logic [2:0]               addr_q;
    logic [COUNTER_WIDTH-1:0] buf_q;
    logic [COUNTER_WIDTH-1:0] buf_d;
    logic [2:0]               byte_cnt_q;
    logic [TW-1:0]            tmo_q;
    logic [2:0]               cfg_address_q;
    logic [COUNTER_WIDTH-1:0] cfg_value_q;
    logic [7:0]               ack_data_q;
    logic                     ack_valid_q;
    logic                     error_q;
    logic                     reserved;
    logic                     store_now;
`ifdef UART_CFG_CHECKSUM_EN
    logic [7:0]               csum_q;
`endif

    // The strobe must appear in the very cycle COMMIT sees the transmitter
    // idle, so strobe and the address/value it carries bypass the held copies.
    assign reserved    = (addr_q[2:1] == 2'b11);
    assign store_now   = (state_q == S_COMMIT) && !reserved && !tx_busy;
    assign cfg_store   = store_now;
    assign cfg_address = store_now ? addr_q : cfg_address_q;
    assign cfg_value   = store_now ? buf_q  : cfg_value_q;
    assign ack_data    = ack_data_q;
    assign ack_valid   = ack_valid_q;
    assign error       = error_q;

    // Drop the incoming byte into lane byte_cnt_q; lanes past the top are discarded.
    always_comb begin
        buf_d = buf_q;
        for (int i = 0; i < COUNTER_WIDTH; i++) begin
            if ((i / 8) == int'(byte_cnt_q)) begin
                buf_d[i] = rx_data[i % 8];
            end
        end
    end

    // Command sequencing FSM with registered response and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            buf_q         <= '0;
            byte_cnt_q    <= '0;
            tmo_q         <= '0;
            cfg_address_q <= '0;
            cfg_value_q   <= '0;
            ack_data_q    <= '0;
            ack_valid_q   <= 1'b0;
            error_q       <= 1'b0;
`ifdef UART_CFG_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            error_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data[7:5] == 3'b101) begin
                            addr_q     <= rx_data[2:0];
                            buf_q      <= '0;
                            byte_cnt_q <= '0;
                            tmo_q      <= '0;
`ifdef UART_CFG_CHECKSUM_EN
                            csum_q     <= rx_data;
`endif
                            state_q    <= S_COLLECT;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (rx_valid) begin
                        buf_q      <= buf_d;
                        tmo_q      <= '0;
                        byte_cnt_q <= byte_cnt_q + 3'd1;
`ifdef UART_CFG_CHECKSUM_EN
                        csum_q     <= csum_q ^ rx_data;
                        if (byte_cnt_q == VB_LAST) state_q <= S_CHECK;
`else
                        if (byte_cnt_q == VB_LAST) state_q <= S_COMMIT;
`endif
                    end else if (tmo_q == TMO_LAST) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
`ifdef UART_CFG_CHECKSUM_EN
                S_CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            state_q <= S_COMMIT;
                        end else begin
                            ack_data_q  <= {5'b11000, addr_q};
                            ack_valid_q <= 1'b1;
                            error_q     <= 1'b1;
                            state_q     <= S_ACK;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
`endif
                S_COMMIT: begin
                    if (rx_valid) error_q <= 1'b1;
                    if (reserved) begin
                        ack_data_q  <= {5'b11100, addr_q};
                        ack_valid_q <= 1'b1;
                        state_q     <= S_ACK;
                    end else if (!tx_busy) begin
                        cfg_address_q <= addr_q;
                        cfg_value_q   <= buf_q;
                        ack_data_q    <= {5'b10100, addr_q};
                        ack_valid_q   <= 1'b1;
                        state_q       <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (rx_valid) error_q <= 1'b1;
                    if (ack_ready) begin
                        ack_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
